// File: rtl/mips_hazard_if.sv
// Hazard-controller bundle between the MIPS pipeline datapath and
// mips_hazard_ctrl. Performance-counter signals exist only when
// HAZARD_PERF_CNT_EN is defined.
interface mips_hazard_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int unsigned CNTW = 32)
`endif
  ;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD;
  logic       MemReqM, MemReadyM;

  logic       StallF, StallD, RegClrD, FlushE;
  logic       StallE, StallM, FlushW;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemTimeout;

`ifdef HAZARD_PERF_CNT_EN
  logic            PerfClr;
  logic [CNTW-1:0] StallCycles, FlushCount;
`endif

  // Datapath side: drives pipeline-register fields, consumes controls
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, PCSrcD, MemReqM, MemReadyM,
`ifdef HAZARD_PERF_CNT_EN
    output PerfClr,
    input  StallCycles, FlushCount,
`endif
    input  StallF, StallD, RegClrD, FlushE, StallE, StallM, FlushW,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MemTimeout
  );

  // Controller side
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcD, MemReqM, MemReadyM,
`ifdef HAZARD_PERF_CNT_EN
    input  PerfClr,
    output StallCycles, FlushCount,
`endif
    output StallF, StallD, RegClrD, FlushE, StallE, StallM, FlushW,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE, MemTimeout
  );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline: forwarding
// selects, load-use / branch stalls, and a memory wait-state FSM with a
// bounded wait and a sticky timeout error.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters).
module mips_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNTW = 32
`endif
) (
  input logic          clk,
  input logic          reset,
  mips_hazard_if.slave hz
);

  localparam int unsigned WCNTW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WCNTW-1:0] wcnt, wcnt_nxt;

  logic lwstall, branchstall, memstall;
  logic stall_fd, flush_e, regclr_d;
  logic mem_pending;

  // Stall and flush terms; ERR forces a permanent memory stall
  always_comb begin
    mem_pending = hz.MemReqM & ~hz.MemReadyM;
    lwstall     = hz.MemtoRegE & ((hz.RtE == hz.RsD) | (hz.RtE == hz.RtD));
    branchstall = hz.BranchD &
                  ((hz.RegWriteE & ((hz.WriteRegE == hz.RsD) | (hz.WriteRegE == hz.RtD))) |
                   (hz.MemtoRegM & ((hz.WriteRegM == hz.RsD) | (hz.WriteRegM == hz.RtD))));
    memstall    = (state == S_ERR) | mem_pending;
    stall_fd    = lwstall | branchstall | memstall;
    flush_e     = (lwstall | branchstall) & ~memstall;
    regclr_d    = hz.PCSrcD & ~stall_fd;
  end

  // Pipeline control outputs
  always_comb begin
    hz.StallF     = stall_fd;
    hz.StallD     = stall_fd;
    hz.RegClrD    = regclr_d;
    hz.FlushE     = flush_e;
    hz.StallE     = memstall;
    hz.StallM     = memstall;
    hz.FlushW     = memstall;
    hz.MemTimeout = (state == S_ERR);
  end

  // Forwarding selects; M stage has priority over W, $0 never forwarded
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if ((hz.RsE != 5'd0) && hz.RegWriteM && (hz.RsE == hz.WriteRegM))
      hz.ForwardAE = 2'b10;
    else if ((hz.RsE != 5'd0) && hz.RegWriteW && (hz.RsE == hz.WriteRegW))
      hz.ForwardAE = 2'b01;
    if ((hz.RtE != 5'd0) && hz.RegWriteM && (hz.RtE == hz.WriteRegM))
      hz.ForwardBE = 2'b10;
    else if ((hz.RtE != 5'd0) && hz.RegWriteW && (hz.RtE == hz.WriteRegW))
      hz.ForwardBE = 2'b01;
    hz.ForwardAD = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.RsD == hz.WriteRegM);
    hz.ForwardBD = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.RtD == hz.WriteRegM);
  end

  // Wait-state FSM state and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: wcnt counts stalled cycles of the current access; the
  // TIMEOUT-th consecutive stalled cycle moves to ERR. A dropped request
  // while waiting counts as completion.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_RUN: begin
        if (mem_pending) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = WCNTW'(1);
        end else begin
          wcnt_nxt  = '0;
        end
      end
      S_WAIT: begin
        if (!mem_pending) begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNTW'(TIMEOUT - 1)) begin
          state_nxt = S_ERR;
          wcnt_nxt  = WCNTW'(TIMEOUT);
        end else begin
          wcnt_nxt  = wcnt + WCNTW'(1);
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  // Saturating stall/flush counters; PerfClr has priority over counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.PerfClr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fd && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNTW'(1);
      if ((flush_e || regclr_d) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

  assign hz.StallCycles = stall_cnt;
  assign hz.FlushCount  = flush_cnt;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl (TIMEOUT=4). Directed scenarios
// plus randomized cycles compared against a cycle-level reference model.
module tb_mips_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned CNTW = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  mips_hazard_if #(.CNTW(CNTW)) hz();
  mips_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (.clk(clk), .reset(reset), .hz(hz));
`else
  mips_hazard_if hz();
  mips_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .hz(hz));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: consecutive stalled memory cycles, sticky error
  int m_run = 0;
  bit m_err = 1'b0;

  function automatic logic [13:0] observed();
    return {hz.StallF, hz.StallD, hz.RegClrD, hz.FlushE, hz.StallE, hz.StallM,
            hz.FlushW, hz.ForwardAD, hz.ForwardBD, hz.ForwardAE, hz.ForwardBE,
            hz.MemTimeout};
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (src != 5'd0 && hz.RegWriteM && src == hz.WriteRegM) return 2'b10;
    if (src != 5'd0 && hz.RegWriteW && src == hz.WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [13:0] expected();
    logic lw, br, mem, st, fe, rc, fad, fbd;
    lw  = hz.MemtoRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
    br  = hz.BranchD &&
          ((hz.RegWriteE && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
           (hz.MemtoRegM && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
    mem = m_err || (hz.MemReqM && !hz.MemReadyM);
    st  = lw || br || mem;
    fe  = (lw || br) && !mem;
    rc  = hz.PCSrcD && !st;
    fad = hz.RsD != 5'd0 && hz.RegWriteM && hz.RsD == hz.WriteRegM;
    fbd = hz.RtD != 5'd0 && hz.RegWriteM && hz.RtD == hz.WriteRegM;
    return {st, st, rc, fe, mem, mem, mem, fad, fbd, fwd_e(hz.RsE), fwd_e(hz.RtE), m_err};
  endfunction

  task automatic clear_inputs();
    hz.RsD = '0; hz.RtD = '0; hz.RsE = '0; hz.RtE = '0;
    hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
    hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
    hz.BranchD = 1'b0; hz.PCSrcD = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    hz.PerfClr = 1'b0;
`endif
  endtask

  // Advance model with the current inputs, then step one clock (ends at edge+1)
  task automatic tick();
    if (!m_err) begin
      if (hz.MemReqM && !hz.MemReadyM) begin
        m_run++;
        if (m_run >= int'(TIMEOUT)) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    m_run = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #1;
    n_checks++;
    if (observed() !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", observed(), 14'd0);
    end
    hz.RsE = 5'd5; hz.WriteRegM = 5'd5; hz.RegWriteM = 1'b1;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b10) begin
      n_fail++; $display("FAIL reset_comb_follow: got %b want %b", hz.ForwardAE, 2'b10);
    end
    do_reset();
    #1;
    n_checks++;
    if (observed() !== 14'd0) begin
      n_fail++; $display("FAIL post_reset_outputs: got %h want %h", observed(), 14'd0);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hz.RsE = 5'd5; hz.WriteRegM = 5'd5; hz.RegWriteM = 1'b1;
    hz.WriteRegW = 5'd5; hz.RegWriteW = 1'b1;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b10) begin
      n_fail++; $display("FAIL fwd_ae_m_priority: got %b want %b", hz.ForwardAE, 2'b10);
    end
    hz.RegWriteM = 1'b0;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b01) begin
      n_fail++; $display("FAIL fwd_ae_w: got %b want %b", hz.ForwardAE, 2'b01);
    end
    hz.RsE = 5'd0; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd0; hz.WriteRegW = 5'd0;
    #1;
    n_checks++;
    if (hz.ForwardAE !== 2'b00) begin
      n_fail++; $display("FAIL fwd_ae_reg0: got %b want %b", hz.ForwardAE, 2'b00);
    end
    hz.RtE = 5'd7; hz.WriteRegM = 5'd7; hz.RtD = 5'd7; hz.RsD = 5'd7;
    #1;
    n_checks++;
    if ({hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !== 4'b1011) begin
      n_fail++; $display("FAIL fwd_be_d: got %b want %b",
                         {hz.ForwardBE, hz.ForwardAD, hz.ForwardBD}, 4'b1011);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.MemtoRegE = 1'b1; hz.RtE = 5'd8; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8;
    hz.RsD = 5'd8;
    #1;
    n_checks++;
    if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b111) begin
      n_fail++; $display("FAIL lwstall_on: got %b want %b", {hz.StallF, hz.StallD, hz.FlushE}, 3'b111);
    end
    tick();
    clear_inputs();
    hz.MemtoRegM = 1'b1; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd8; hz.RsD = 5'd8;
    #1;
    n_checks++;
    if ({hz.StallF, hz.StallD, hz.FlushE, hz.ForwardAD} !== 4'b0001) begin
      n_fail++; $display("FAIL lwstall_off: got %b want %b",
                         {hz.StallF, hz.StallD, hz.FlushE, hz.ForwardAD}, 4'b0001);
    end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    hz.BranchD = 1'b1; hz.RsD = 5'd3; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd3;
    #1;
    n_checks++;
    if ({hz.StallF, hz.StallD, hz.FlushE, hz.RegClrD} !== 4'b1110) begin
      n_fail++; $display("FAIL branchstall_on: got %b want %b",
                         {hz.StallF, hz.StallD, hz.FlushE, hz.RegClrD}, 4'b1110);
    end
    tick();
    hz.RegWriteE = 1'b0; hz.WriteRegE = 5'd0;
    hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd3; hz.PCSrcD = 1'b1;
    #1;
    n_checks++;
    if ({hz.StallD, hz.RegClrD, hz.ForwardAD} !== 3'b011) begin
      n_fail++; $display("FAIL branch_taken_clr: got %b want %b",
                         {hz.StallD, hz.RegClrD, hz.ForwardAD}, 3'b011);
    end
    hz.RegWriteM = 1'b0; hz.MemtoRegM = 1'b1; hz.RsD = 5'd1; hz.RtD = 5'd3;
    #1;
    n_checks++;
    if ({hz.StallD, hz.RegClrD, hz.FlushE} !== 3'b101) begin
      n_fail++; $display("FAIL branch_load_m: got %b want %b",
                         {hz.StallD, hz.RegClrD, hz.FlushE}, 3'b101);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int hi = 0;
    bit done = 1'b0;
    clear_inputs();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
    #1;
    n_checks++;
    if (hz.StallE !== 1'b0) begin
      n_fail++; $display("FAIL mem_zero_wait: got %b want %b", hz.StallE, 1'b0);
    end
    tick();
    for (int c = 0; c < 10 && !done; c++) begin
      hz.MemReadyM = (c >= 3);
      #1;
      if (hz.StallE === 1'b1) hi++;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++; $display("FAIL mem_wait_cycle%0d: got %h want %h", c, observed(), expected());
      end
      done = hz.MemReadyM;
      tick();
    end
    n_checks++;
    if (hi != 3) begin
      n_fail++; $display("FAIL mem_wait_len: got %0d want %0d", hi, 3);
    end
    // Overlapping load-use and memory wait: FlushE held off until memory completes
    clear_inputs();
    hz.MemtoRegE = 1'b1; hz.RtE = 5'd9; hz.RsD = 5'd9; hz.MemReqM = 1'b1;
    for (int c = 0; c < 3; c++) begin
      hz.MemReadyM = (c == 2);
      #1;
      n_checks++;
      if ({hz.StallF, hz.FlushE, hz.StallE} !== ((c == 2) ? 3'b110 : 3'b101)) begin
        n_fail++; $display("FAIL lw_mem_overlap%0d: got %b want %b", c,
                           {hz.StallF, hz.FlushE, hz.StallE}, ((c == 2) ? 3'b110 : 3'b101));
      end
      tick();
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_timeout();
    int seen = -1;
    do_reset();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got %h want %h", c, observed(), expected());
      end
      if (hz.MemTimeout === 1'b1 && seen < 0) seen = c;
      tick();
    end
    n_checks++;
    if (seen != int'(TIMEOUT)) begin
      n_fail++; $display("FAIL timeout_entry: got %0d want %0d", seen, TIMEOUT);
    end
    // Sticky error: ready/drop of request changes nothing, flush and clear suppressed
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b1; hz.PCSrcD = 1'b1;
    hz.MemtoRegE = 1'b1; hz.RtE = 5'd4; hz.RsD = 5'd4;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (observed() !== 14'b11_0_0_111_00_00_00_1) begin
        n_fail++; $display("FAIL timeout_sticky%0d: got %h want %h", c, observed(),
                           14'b11_0_0_111_00_00_00_1);
      end
      tick();
    end
    clear_inputs();
    #1;
    reset = 1'b1;
    m_run = 0;
    m_err = 1'b0;
    #1;
    n_checks++;
    if ({hz.MemTimeout, hz.StallE, hz.StallF} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_async_reset: got %b want %b",
                         {hz.MemTimeout, hz.StallE, hz.StallF}, 3'b000);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    tick();
    tick();
    #1;
    reset = 1'b1;
    m_run = 0;
    m_err = 1'b0;
    #1;
    n_checks++;
    if ({hz.StallE, hz.MemTimeout} !== 2'b10) begin
      n_fail++; $display("FAIL midwait_reset: got %b want %b", {hz.StallE, hz.MemTimeout}, 2'b10);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      hz.MemReadyM = (c == 3);
      #1;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++; $display("FAIL midwait_resume%0d: got %h want %h", c, observed(), expected());
      end
      tick();
    end
    n_checks++;
    if (hz.MemTimeout !== 1'b0) begin
      n_fail++; $display("FAIL midwait_no_timeout: got %b want %b", hz.MemTimeout, 1'b0);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (m_err && $urandom_range(0, 3) == 0) do_reset();
      hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
      hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
      hz.WriteRegE = 5'($urandom_range(0, 3));
      hz.WriteRegM = 5'($urandom_range(0, 3));
      hz.WriteRegW = 5'($urandom_range(0, 3));
      hz.RegWriteE = 1'($urandom_range(0, 1)); hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MemtoRegE = 1'($urandom_range(0, 1)); hz.MemtoRegM = 1'($urandom_range(0, 1));
      hz.BranchD = 1'($urandom_range(0, 1)); hz.PCSrcD = 1'($urandom_range(0, 1));
      hz.MemReqM = 1'($urandom_range(0, 1));
      hz.MemReadyM = ($urandom_range(0, 4) != 0);
      #1;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", c, observed(), expected());
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    #1;
    n_checks++;
    if ({hz.StallCycles, hz.FlushCount} !== 8'h00) begin
      n_fail++; $display("FAIL perf_reset: got %h want %h", {hz.StallCycles, hz.FlushCount}, 8'h00);
    end
    hz.MemtoRegE = 1'b1; hz.RtE = 5'd8; hz.RsD = 5'd8;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        n_checks++;
        if (hz.StallCycles !== 4'd5) begin
          n_fail++; $display("FAIL perf_count5: got %0d want %0d", hz.StallCycles, 5);
        end
      end
      tick();
    end
    n_checks++;
    if ({hz.StallCycles, hz.FlushCount} !== 8'hFF) begin
      n_fail++; $display("FAIL perf_saturate: got %h want %h", {hz.StallCycles, hz.FlushCount}, 8'hFF);
    end
    hz.PerfClr = 1'b1;
    tick();
    n_checks++;
    if ({hz.StallCycles, hz.FlushCount} !== 8'h00) begin
      n_fail++; $display("FAIL perf_clear: got %h want %h", {hz.StallCycles, hz.FlushCount}, 8'h00);
    end
    hz.PerfClr = 1'b0;
    tick();
    n_checks++;
    if ({hz.StallCycles, hz.FlushCount} !== 8'h11) begin
      n_fail++; $display("FAIL perf_restart: got %h want %h", {hz.StallCycles, hz.FlushCount}, 8'h11);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
